// File: rtl/xeng_vacc_pkg.sv
// Shared definitions for the X-engine vector accumulator.
// Derives the tap word width (CW), component count (NC) and baseline count
// (N_BLS) from the X-engine parameters, so every user of the tap chain
// computes them the same way.
package xeng_vacc_pkg;

    // Width of the acc_len and dump_cnt fields.
    localparam int LEN_W = 16;

    // Bits per tap output component: the product of two BITWIDTH samples, one
    // growth bit for the re/im cross sum, then parallel and serial accumulation.
    function automatic int calc_cw(input int serial_bits, input int p_bits, input int bitwidth);
        return 2 * bitwidth + 1 + p_bits + serial_bits;
    endfunction

    // Components per baseline word: re/im for each of the N_POLS^2 Stokes products.
    function automatic int calc_nc(input int n_pols);
        return 2 * n_pols * n_pols;
    endfunction

    // Baselines emitted per X-engine window.
    function automatic int calc_n_bls(input int n_ants);
        return n_ants * (n_ants / 2 + 1);
    endfunction

    // An acc_len of zero integrates a single window.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len == '0) ? LEN_W'(1) : len;
    endfunction

endpackage

// File: rtl/xeng_vacc_if.sv
// Bus between the accumulator and its environment.
//   sync_in / acc_len      frame control from the X-engine
//   din / din_valid        baseline words from the last tap; cannot be stalled
//   dout / dout_valid /
//   dout_ready / dout_last dump output stream
//   overflow / dump_cnt    status
// Output handshake: a word transfers on every rising clock edge where
// dout_valid and dout_ready are both high; while dout_valid is high and
// dout_ready is low, dout and dout_last hold their value; dout_valid never
// depends on dout_ready. The input side has no ready: din is taken on every
// edge where din_valid is high (once armed).
interface xeng_vacc_if
    import xeng_vacc_pkg::*;
#(
    parameter int IN_W  = 128,
    parameter int OUT_W = 256
);
    logic             sync_in;
    logic [LEN_W-1:0] acc_len;
    logic [IN_W-1:0]  din;
    logic             din_valid;
    logic [OUT_W-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             dout_last;
    logic             overflow;
    logic [LEN_W-1:0] dump_cnt;

    modport slave (
        input  sync_in, acc_len, din, din_valid, dout_ready,
        output dout, dout_valid, dout_last, overflow, dump_cnt
    );

    modport master (
        output sync_in, acc_len, din, din_valid, dout_ready,
        input  dout, dout_valid, dout_last, overflow, dump_cnt
    );
endinterface

// File: rtl/xeng_vacc_fifo.sv
// First-word-fall-through FIFO holding 2^DEPTH_BITS words.
//   clk, rst_n      clock, asynchronous active-low reset
//   push, push_data write request; dropped when full unless a pop happens
//   pop_ready       consumer ready; pop = rd_valid & pop_ready
//   rd_data         head word, forced to 0 while empty
//   rd_valid        head word present
//   dropped         a push was refused this cycle
// The head is held in an output register that is loaded from storage, so a
// word written into an empty FIFO appears one cycle after its write edge.
// Storage alone sets the capacity; the output register is a copy of the head.
module xeng_vacc_fifo
    import xeng_vacc_pkg::*;
#(
    parameter int W          = 257,
    parameter int DEPTH_BITS = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop_ready,
    output logic [W-1:0] rd_data,
    output logic         rd_valid,
    output logic         dropped
);
    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [W-1:0]          mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS-1:0] rd_next;
    logic [DEPTH_BITS:0]   count;
    logic [DEPTH_BITS:0]   count_kept;
    logic [W-1:0]          out_data;
    logic                  out_valid;
    logic                  pop;
    logic                  full;
    logic                  wr_en;

    always_comb begin
        pop        = out_valid & pop_ready;
        full       = (count == (DEPTH_BITS + 1)'(DEPTH));
        wr_en      = push & (~full | pop);
        dropped    = push & ~wr_en;
        rd_next    = rd_ptr + DEPTH_BITS'(pop);
        // Words already in storage before this edge, after the pop.
        count_kept = count - (DEPTH_BITS + 1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + DEPTH_BITS'(1);
            end
            rd_ptr    <= rd_next;
            count     <= count_kept + (DEPTH_BITS + 1)'(wr_en);
            // Only words written on earlier edges feed the head register, so
            // the read below never races the write at the same edge.
            out_valid <= (count_kept != '0);
            out_data  <= mem[rd_next];
        end
    end

    assign rd_valid = out_valid;
    assign rd_data  = out_valid ? out_data : '0;

endmodule

// File: rtl/xeng_vacc.sv
// Vector accumulator behind the X-engine tap chain.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         xeng_vacc_if slave: sync_in/acc_len frame control, din/din_valid
//               baseline words, dout stream with dout_valid/dout_ready/dout_last,
//               sticky overflow and dump_cnt status
// Each baseline word is summed component-wise into an on-chip RAM over acc_len
// windows with a three-stage read-modify-write; the final window's sums go to
// an output FIFO. The RAM address for a baseline comes round again only after
// N_BLS words, so the pipeline needs no read-after-write bypass.
module xeng_vacc
    import xeng_vacc_pkg::*;
#(
    parameter int SERIAL_ACC_LEN_BITS = 7,
    parameter int P_FACTOR_BITS       = 0,
    parameter int BITWIDTH            = 4,
    parameter int N_POLS              = 2,
    parameter int N_ANTS              = 8,
    parameter int VACC_BITS           = 32,
    parameter int FIFO_DEPTH_BITS     = 5
) (
    input logic        clk,
    input logic        rst_n,
    xeng_vacc_if.slave bus
);
    localparam int CW    = calc_cw(SERIAL_ACC_LEN_BITS, P_FACTOR_BITS, BITWIDTH);
    localparam int NC    = calc_nc(N_POLS);
    localparam int N_BLS = calc_n_bls(N_ANTS);
    localparam int BL_W  = $clog2(N_BLS);
    localparam int OUT_W = NC * VACC_BITS;

    // Frame / index state
    logic             armed;
    logic [LEN_W-1:0] len_q;
    logic [BL_W-1:0]  bl_idx;
    logic [LEN_W-1:0] int_idx;

    // Indices that apply to the word on din this cycle; a sync_in in the same
    // cycle makes that word the first of the new frame.
    logic             accept;
    logic [BL_W-1:0]  cur_bl;
    logic [LEN_W-1:0] cur_int;
    logic [LEN_W-1:0] eff_len;
    logic             cur_first;
    logic             cur_dump;
    logic             cur_bl_wrap;
    logic [OUT_W-1:0] ext;

    // Pipeline stages
    logic             s1_valid, s1_first, s1_dump, s1_last;
    logic [BL_W-1:0]  s1_bl;
    logic [OUT_W-1:0] s1_ext;
    logic [OUT_W-1:0] ram_q;
    logic [OUT_W-1:0] sum;
    logic [VACC_BITS-1:0] prev;
    logic [VACC_BITS:0]   wide;
    logic             s2_valid, s2_dump, s2_last;
    logic [BL_W-1:0]  s2_bl;
    logic [OUT_W-1:0] s2_sum;
    logic             ram_wr;
    logic             push;
    logic             dropped;

    logic [OUT_W-1:0] ram [N_BLS];
    logic [OUT_W:0]   fifo_rd;

    always_comb begin
        accept      = bus.din_valid & (armed | bus.sync_in);
        cur_bl      = bus.sync_in ? '0 : bl_idx;
        cur_int     = bus.sync_in ? '0 : int_idx;
        eff_len     = bus.sync_in ? clamp_len(bus.acc_len) : len_q;
        cur_first   = (cur_int == '0);
        cur_dump    = (cur_int == eff_len - LEN_W'(1));
        cur_bl_wrap = (cur_bl == BL_W'(N_BLS - 1));
    end

    always_comb begin
        ext = '0;
        for (int k = 0; k < NC; k++) begin
            ext[k*VACC_BITS +: VACC_BITS] = VACC_BITS'($signed(bus.din[k*CW +: CW]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed   <= 1'b0;
            len_q   <= LEN_W'(1);
            bl_idx  <= '0;
            int_idx <= '0;
        end else begin
            if (bus.sync_in) begin
                armed <= 1'b1;
                len_q <= clamp_len(bus.acc_len);
            end
            if (accept) begin
                if (cur_bl_wrap) begin
                    bl_idx  <= '0;
                    int_idx <= cur_dump ? '0 : cur_int + LEN_W'(1);
                end else begin
                    bl_idx  <= cur_bl + BL_W'(1);
                    int_idx <= cur_int;
                end
            end else if (bus.sync_in) begin
                bl_idx  <= '0;
                int_idx <= '0;
            end
        end
    end

    // S0: register the extended word and its flags; RAM read is issued here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_dump  <= 1'b0;
            s1_last  <= 1'b0;
            s1_bl    <= '0;
            s1_ext   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_first <= cur_first;
                s1_dump  <= cur_dump;
                s1_last  <= cur_bl_wrap;
                s1_bl    <= cur_bl;
                s1_ext   <= ext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            ram[s2_bl] <= s2_sum;
        end
        ram_q <= ram[cur_bl];
    end

    // S1: add with one guard bit; a guard/sign disagreement means the true sum
    // left the VACC_BITS range, and the guard bit gives the direction.
    always_comb begin
        sum  = '0;
        prev = '0;
        wide = '0;
        for (int k = 0; k < NC; k++) begin
            prev = s1_first ? '0 : ram_q[k*VACC_BITS +: VACC_BITS];
            wide = {prev[VACC_BITS-1], prev}
                 + {s1_ext[k*VACC_BITS+VACC_BITS-1], s1_ext[k*VACC_BITS +: VACC_BITS]};
            if (wide[VACC_BITS] != wide[VACC_BITS-1]) begin
                sum[k*VACC_BITS +: VACC_BITS] = wide[VACC_BITS]
                    ? {1'b1, {(VACC_BITS-1){1'b0}}}
                    : {1'b0, {(VACC_BITS-1){1'b1}}};
            end else begin
                sum[k*VACC_BITS +: VACC_BITS] = wide[VACC_BITS-1:0];
            end
        end
    end

    // A sync_in kills the words still in S1 and S2 so a stale frame cannot
    // write RAM or emit a dump word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_dump  <= 1'b0;
            s2_last  <= 1'b0;
            s2_bl    <= '0;
            s2_sum   <= '0;
        end else begin
            s2_valid <= s1_valid & ~bus.sync_in;
            if (s1_valid) begin
                s2_dump <= s1_dump;
                s2_last <= s1_last;
                s2_bl   <= s1_bl;
                s2_sum  <= sum;
            end
        end
    end

    // S2: write back, and push when this is the final window of the dump.
    always_comb begin
        ram_wr = s2_valid & ~bus.sync_in;
        push   = ram_wr & s2_dump;
    end

    xeng_vacc_fifo #(
        .W          (OUT_W + 1),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({s2_last, s2_sum}),
        .pop_ready (bus.dout_ready),
        .rd_data   (fifo_rd),
        .rd_valid  (bus.dout_valid),
        .dropped   (dropped)
    );

    assign bus.dout      = fifo_rd[OUT_W-1:0];
    assign bus.dout_last = fifo_rd[OUT_W];

    // dump_cnt counts the last-word push of every dump, even when the FIFO
    // drops it, so it tracks integration progress rather than delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.overflow <= 1'b0;
            bus.dump_cnt <= '0;
        end else if (bus.sync_in) begin
            bus.overflow <= 1'b0;
            bus.dump_cnt <= '0;
        end else begin
            if (dropped) begin
                bus.overflow <= 1'b1;
            end
            if (push && s2_last) begin
                bus.dump_cnt <= bus.dump_cnt + LEN_W'(1);
            end
        end
    end

endmodule
